hdmi_i2c_writer: RTL and testbench

I2C master engine that performs single-register writes to the HDMI transmitter over the board's open-drain I2C pins. It sits directly beneath the HDMI init sequencer in the 50 MHz domain. The sequencer hands it one (register, data) pair at a time. The engine emits START, device address plus write bit, register, data and STOP, checking each ACK. It honours slave clock stretching and reports completion and NACK status back upstream.

---
 rtl/hdmi_i2c_pkg.sv | 37 +++
 rtl/i2c_quarter_tick.sv | 40 ++++
 rtl/hdmi_i2c_writer.sv | 195 +++++++++++++++++++
 tb/tb_hdmi_i2c_writer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_i2c_pkg.sv
// hdmi_i2c_pkg
//   Shared types and constants for the HDMI transmitter I2C path. The init
//   sequencer and the write engine both import this package.
//   - i2c_state_e : engine states IDLE/START/SHIFT/STOP
//   - i2c_phase_e : quarter phases q0..q3 of one bit-symbol
//   - qdiv()      : clock cycles per quarter phase
//   - HDMI_TX_BUS_BYTE : address byte (7-bit address + write bit) of the HDMI TX
package hdmi_i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_SHIFT = 2'd2,
      ST_STOP  = 2'd3
   } i2c_state_e;

   typedef enum logic [1:0] {
      PH_Q0 = 2'd0,
      PH_Q1 = 2'd1,
      PH_Q2 = 2'd2,
      PH_Q3 = 2'd3
   } i2c_phase_e;

   localparam logic [7:0] HDMI_TX_BUS_BYTE = 8'h72;

   // Bit index 0..7 are data bits, index 8 is the ACK slot of each byte.
   localparam logic [3:0] ACK_BIT = 4'd8;

   // The last byte of a write is number 2 (address, register, data).
   localparam logic [1:0] LAST_BYTE = 2'd2;

   function automatic int unsigned qdiv(input int unsigned clk_hz,
                                        input int unsigned i2c_hz);
      return clk_hz / (4 * i2c_hz);
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick
//   Quarter-phase prescaler for the I2C engine. Counts QDIV cycles per
//   quarter and pulses tick_o on the last cycle of each quarter.
//   Ports:
//     clk_i  : clock
//     rst_i  : asynchronous active-high reset, counter returns to 0
//     en_i   : count enable; while low the counter is parked at 0
//     hold_i : freeze the counter (slave clock stretching)
//     tick_o : end-of-quarter pulse
module i2c_quarter_tick #(
   parameter int unsigned QDIV = 125
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic hold_i,
   output logic tick_o
);

   localparam int unsigned   CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i)               cnt_d = '0;
      else if (hold_i)         cnt_d = cnt_q;
      else if (cnt_q == LAST)  cnt_d = '0;
      else                     cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = en_i && !hold_i && (cnt_q == LAST);

endmodule

// File: rtl/hdmi_i2c_writer.sv
// hdmi_i2c_writer
//   I2C master that performs one register write to the HDMI transmitter per
//   request: START, {DEV_ADDR,W}, REG, DATA, STOP, checking each ACK and
//   honouring slave clock stretching.
//   Ports:
//     CLK_50MHZ          : clock
//     RESET              : asynchronous active-high reset
//     REQ_VALID/REQ_READY: request handshake; REQ_REG/REQ_DATA latched on accept
//     BUSY               : transaction in progress
//     DONE               : one-cycle pulse on the last cycle of STOP
//     NACK               : last transaction saw a NACK (cleared on next accept)
//     I2C_SCL/I2C_SDA    : open-drain bus lines (drive 0 or Z)
module hdmi_i2c_writer
   import hdmi_i2c_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned I2C_HZ   = 100_000,
   parameter logic [6:0]  DEV_ADDR = HDMI_TX_BUS_BYTE[7:1]
) (
   input  logic       CLK_50MHZ,
   input  logic       RESET,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic [7:0] REQ_REG,
   input  logic [7:0] REQ_DATA,
   output logic       BUSY,
   output logic       DONE,
   output logic       NACK,
   inout  wire        I2C_SCL,
   inout  wire        I2C_SDA
);

   localparam int unsigned QDIV = qdiv(CLK_HZ, I2C_HZ);

   i2c_state_e state_q, state_d;
   i2c_phase_e ph_q, ph_d;
   logic [3:0] bit_q, bit_d;
   logic [1:0] byte_q, byte_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] reg_q, reg_d;
   logic [7:0] data_q, data_d;
   logic       nack_q, nack_d;
   logic       scl_lo_q, scl_lo_d;
   logic       sda_lo_q, sda_lo_d;
   logic       scl_rel1_q, scl_rel2_q;
   logic [1:0] scl_sync_q, sda_sync_q;

   logic scl_in, sda_in;
   logic tick, hold, cnt_en, accept, done_now;

   assign scl_in = scl_sync_q[1];
   assign sda_in = sda_sync_q[1];

   // The synchronised SCL lags our own release by two cycles, so it is only
   // trusted once SCL has been released for that long. Earlier, a low
   // reading is just our own drive echoing back rather than a stretching
   // slave. The counter therefore freezes a couple of counts into the
   // quarter, and the quarter is lengthened by exactly the time the slave
   // kept SCL low after our release.
   assign hold = (state_q != ST_IDLE) && !scl_lo_q && scl_rel1_q && scl_rel2_q && !scl_in;

   // In IDLE the ready flag is always high, so REQ_VALID alone marks an
   // accept. Using it here avoids a loop through tick -> done -> ready.
   // The accept cycle itself counts as the first cycle of START q0.
   assign cnt_en = (state_q != ST_IDLE) || REQ_VALID;

   i2c_quarter_tick #(.QDIV(QDIV)) u_qtick (
      .clk_i  (CLK_50MHZ),
      .rst_i  (RESET),
      .en_i   (cnt_en),
      .hold_i (hold),
      .tick_o (tick)
   );

   assign done_now  = (state_q == ST_STOP) && (ph_q == PH_Q3) && tick;
   assign REQ_READY = (state_q == ST_IDLE) || done_now;
   assign BUSY      = (state_q != ST_IDLE) && !done_now;
   assign DONE      = done_now;
   assign NACK      = nack_q;
   assign accept    = REQ_VALID && REQ_READY;

   assign I2C_SCL = scl_lo_q ? 1'b0 : 1'bz;
   assign I2C_SDA = sda_lo_q ? 1'b0 : 1'bz;

   // State register
   always_ff @(posedge CLK_50MHZ or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         ph_q       <= PH_Q0;
         bit_q      <= '0;
         byte_q     <= '0;
         sh_q       <= '0;
         reg_q      <= '0;
         data_q     <= '0;
         nack_q     <= 1'b0;
         scl_lo_q   <= 1'b0;
         sda_lo_q   <= 1'b0;
         scl_rel1_q <= 1'b1;
         scl_rel2_q <= 1'b1;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         sh_q       <= sh_d;
         reg_q      <= reg_d;
         data_q     <= data_d;
         nack_q     <= nack_d;
         scl_lo_q   <= scl_lo_d;
         sda_lo_q   <= sda_lo_d;
         scl_rel1_q <= !scl_lo_q;
         scl_rel2_q <= scl_rel1_q;
         scl_sync_q <= {scl_sync_q[0], I2C_SCL};
         sda_sync_q <= {sda_sync_q[0], I2C_SDA};
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      sh_d    = sh_q;
      reg_d   = reg_q;
      data_d  = data_q;
      nack_d  = nack_q;

      if ((state_q != ST_IDLE) && tick) begin
         ph_d = i2c_phase_e'(ph_q + 2'd1);

         // ACK slot is sampled at the q2->q3 boundary; high means NACK.
         if ((state_q == ST_SHIFT) && (bit_q == ACK_BIT) && (ph_q == PH_Q2) && sda_in)
            nack_d = 1'b1;

         if (ph_q == PH_Q3) begin
            case (state_q)
               ST_START: begin
                  state_d = ST_SHIFT;
                  bit_d   = '0;
                  byte_d  = '0;
                  sh_d    = {DEV_ADDR, 1'b0};
               end
               ST_SHIFT: begin
                  if (bit_q != ACK_BIT) begin
                     bit_d = bit_q + 4'd1;
                     sh_d  = {sh_q[6:0], 1'b0};
                  end else if (nack_q || (byte_q == LAST_BYTE)) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_d  = '0;
                     byte_d = byte_q + 2'd1;
                     sh_d   = (byte_q == 2'd0) ? reg_q : data_q;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end

      // Also covers the back-to-back accept on the DONE cycle.
      if (accept) begin
         state_d = ST_START;
         ph_d    = PH_Q0;
         reg_d   = REQ_REG;
         data_d  = REQ_DATA;
         nack_d  = 1'b0;
      end
   end

   // Output logic: line drives are decoded from the next state so the
   // registered pins change exactly at the start of each quarter.
   always_comb begin
      scl_lo_d = 1'b0;
      sda_lo_d = 1'b0;
      case (state_d)
         ST_START: begin
            sda_lo_d = (ph_d == PH_Q2) || (ph_d == PH_Q3);
            scl_lo_d = (ph_d == PH_Q3);
         end
         ST_SHIFT: begin
            scl_lo_d = (ph_d == PH_Q0) || (ph_d == PH_Q1);
            sda_lo_d = (bit_d != ACK_BIT) && !sh_d[7];
         end
         ST_STOP: begin
            scl_lo_d = (ph_d == PH_Q0);
            sda_lo_d = (ph_d != PH_Q3);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hdmi_i2c_writer.sv
`timescale 1ns/1ps
// Directed bench for hdmi_i2c_writer: bus-level slave model with ACK/NACK
// and clock stretching, byte scoreboard, and cycle-accurate latency checks.
module tb_hdmi_i2c_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld = 1'b0;
   logic [7:0] rreg = '0;
   logic [7:0] rdat = '0;
   logic       rdy, busy, done, nack;
   wire        scl, sda;
   logic       slv_sda = 1'b0;
   logic       slv_scl = 1'b0;

   pullup (scl);
   pullup (sda);
   assign scl = slv_scl ? 1'b0 : 1'bz;
   assign sda = slv_sda ? 1'b0 : 1'bz;

   hdmi_i2c_writer dut (
      .CLK_50MHZ (clk),
      .RESET     (rst),
      .REQ_VALID (vld),
      .REQ_READY (rdy),
      .REQ_REG   (rreg),
      .REQ_DATA  (rdat),
      .BUSY      (busy),
      .DONE      (done),
      .NACK      (nack),
      .I2C_SCL   (scl),
      .I2C_SDA   (sda)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard of bytes expected on the bus, in order.
   logic [7:0] exp_q[$];

   // Bus monitor + slave. Samples lines on the falling clock edge.
   int         n_start = 0, n_stop = 0, done_cnt = 0;
   int         nack_byte = 3;
   int         bitn = 0, bidx = 0;
   logic       p_scl = 1'b1, p_sda = 1'b1;
   logic [7:0] shb = '0;

   always @(negedge clk) begin
      logic s_cl, s_da;
      s_cl = (scl !== 1'b0);
      s_da = (sda !== 1'b0);
      if (done) done_cnt++;
      if (p_scl && s_cl && p_sda && !s_da) begin
         n_start++;
         bitn = 0;
         bidx = 0;
      end else if (p_scl && s_cl && !p_sda && s_da) begin
         n_stop++;
      end else if (!p_scl && s_cl) begin
         if (bitn < 8) begin
            shb = {shb[6:0], s_da};
            bitn++;
            if (bitn == 8) begin
               chk("byte_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) chk("bus_byte", shb, exp_q.pop_front());
            end
         end else begin
            bitn = 0;
            bidx++;
         end
      end else if (p_scl && !s_cl) begin
         slv_sda = (bitn == 8) && (bidx != nack_byte);
      end
      p_scl = s_cl;
      p_sda = s_da;
   end

   int acc = 0;

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Push expected bytes, present the request and wait for the accept.
   // nb = index of the byte the slave NACKs (3 = none).
   task automatic send(input logic [7:0] r, input logic [7:0] d, input int nb);
      int t;
      exp_q.push_back(8'h72);
      if (nb >= 1) exp_q.push_back(r);
      if (nb >= 2) exp_q.push_back(d);
      nack_byte = nb;
      rreg = r;
      rdat = d;
      vld  = 1'b1;
      t = 0;
      while (!rdy && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("accept_ready", rdy, 1);
      acc = cyc;
      @(negedge clk);
      vld = 1'b0;
      chk("acc_busy", busy, 1);
      chk("acc_ready", rdy, 0);
      chk("acc_nack_clr", nack, 0);
   endtask

   // Returns on the sample where DONE is high; dur counts accept..DONE inclusive.
   task automatic wait_done(output int dur);
      int t;
      t = 0;
      while (!done && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", done, 1);
      dur = cyc - acc + 1;
      chk("done_busy", busy, 0);
      chk("done_ready", rdy, 1);
   endtask

   initial begin
      int dur, s0, p0, dc;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", rdy, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_nack", nack, 0);
      chk("rst_scl_rel", scl !== 1'b0, 1);
      chk("rst_sda_rel", sda !== 1'b0, 1);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single write, all ACKed
      s0 = n_start; p0 = n_stop;
      send(8'h41, 8'h10, 3);
      wait_cyc(acc + 249);
      chk("lat_sda_q1", sda !== 1'b0, 1);
      @(negedge clk);
      chk("lat_sda_q2", sda === 1'b0, 1);
      chk("lat_scl_q2", scl !== 1'b0, 1);
      wait_done(dur);
      chk("t1_dur", dur, 14500);
      chk("t1_nack", nack, 0);
      @(negedge clk);
      chk("t1_done_pulse", done, 0);
      chk("t1_drained", exp_q.size(), 0);
      chk("t1_starts", n_start - s0, 1);
      chk("t1_stops", n_stop - p0, 1);

      // Address NACK
      s0 = n_start; p0 = n_stop;
      send(8'h41, 8'h10, 0);
      wait_done(dur);
      chk("t2_dur", dur, 5500);
      chk("t2_nack", nack, 1);
      repeat (10) @(negedge clk);
      chk("t2_nack_held", nack, 1);
      chk("t2_drained", exp_q.size(), 0);
      chk("t2_starts", n_start - s0, 1);
      chk("t2_stops", n_stop - p0, 1);

      // Data NACK on the third byte
      send(8'h22, 8'h5A, 2);
      wait_done(dur);
      chk("t3_dur", dur, 14500);
      chk("t3_nack", nack, 1);
      chk("t3_drained", exp_q.size(), 0);
      repeat (5) @(negedge clk);

      // ACKed request clears NACK on accept; slave stretches SCL in REG bit 5
      // (symbol 12): pull low in q1, release 1000 cycles after the master's q2 release.
      send(8'hA5, 8'hC3, 3);
      wait_cyc(acc + 6200);
      slv_scl = 1'b1;
      wait_cyc(acc + 7000);
      chk("t4_busy_stretch", busy, 1);
      wait_cyc(acc + 7250);
      slv_scl = 1'b0;
      wait_done(dur);
      chk("t4_dur", dur, 15500);
      chk("t4_nack", nack, 0);
      chk("t4_drained", exp_q.size(), 0);
      repeat (5) @(negedge clk);

      // Reset mid-transaction
      dc = done_cnt;
      send(8'h3C, 8'h99, 3);
      wait_cyc(acc + 5000);
      chk("t5_pre_scl_low", scl === 1'b0, 1);
      chk("t5_pre_sda_low", sda === 1'b0, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("t5_rst_scl_rel", scl !== 1'b0, 1);
      chk("t5_rst_sda_rel", sda !== 1'b0, 1);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_ready", rdy, 1);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (300) @(negedge clk);
      chk("t5_no_done", done_cnt - dc, 0);
      chk("t5_idle_ready", rdy, 1);

      // Back-to-back: second request presented while busy, held until DONE
      s0 = n_start; p0 = n_stop; dc = done_cnt;
      send(8'h5E, 8'h01, 3);
      vld = 1'b1;
      rreg = 8'h77;
      rdat = 8'h88;
      exp_q.push_back(8'h72);
      exp_q.push_back(8'h77);
      exp_q.push_back(8'h88);
      wait_cyc(acc + 3000);
      chk("t6_busy_ignored", rdy, 0);
      wait_done(dur);
      chk("t6_first_dur", dur, 14500);
      chk("t6_accept_on_done", rdy && vld, 1);
      acc = cyc;
      @(negedge clk);
      vld = 1'b0;
      chk("t6_second_busy", busy, 1);
      chk("t6_second_done_low", done, 0);
      wait_done(dur);
      chk("t6_nack", nack, 0);
      @(negedge clk);
      chk("t6_drained", exp_q.size(), 0);
      chk("t6_starts", n_start - s0, 2);
      chk("t6_stops", n_stop - p0, 2);
      chk("t6_dones", done_cnt - dc, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
